// File: rtl/amcal3_32bit_approx_mul.sv
// AMCAL3 approximate multiplier back end: multiplies LOD-truncated mantissas and
// rescales by the summed leading-one positions through a 3-stage valid/ready pipeline.
module amcal3_32bit_approx_mul #(
  parameter int FRAC_W  = 3,
  parameter int SHIFT_W = 5,
  parameter int PROD_W  = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FRAC_W-1:0]  a,
  input  logic [FRAC_W-1:0]  b,
  input  logic [SHIFT_W-1:0] ashift,
  input  logic [SHIFT_W-1:0] bshift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PROD_W-1:0]  prod
);

  localparam int M_W = 2 * FRAC_W;
  localparam int E_W = SHIFT_W + 1;
  // Product of two FRAC_W mantissas carries 2*(FRAC_W-1) fraction bits.
  localparam logic [E_W-1:0] BIAS = E_W'(2 * (FRAC_W - 1));

  logic              w_adv;
  logic [E_W-1:0]    w_e_in;
  logic [PROD_W-1:0] w_m_ext;
  logic [PROD_W-1:0] w_prod;

  logic              r_v1, r_v2, r_v3;
  logic [FRAC_W-1:0] r_a1, r_b1;
  logic [E_W-1:0]    r_e1, r_e2;
  logic [M_W-1:0]    r_m2;
  logic [PROD_W-1:0] r_prod;

  // The whole pipe moves as one; it only stalls when the output slot is full and blocked.
  assign w_adv     = ~r_v3 | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v3;
  assign prod      = r_prod;

  assign w_e_in  = E_W'(ashift) + E_W'(bshift);
  assign w_m_ext = PROD_W'(r_m2);

  always_comb begin
    w_prod = '0;
    if (r_e2 >= BIAS) begin
      w_prod = w_m_ext << (r_e2 - BIAS);
    end else begin
      w_prod = w_m_ext >> (BIAS - r_e2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_adv) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  // Data registers only load behind a valid token, so bubbles leave prod untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a1   <= '0;
      r_b1   <= '0;
      r_e1   <= '0;
      r_m2   <= '0;
      r_e2   <= '0;
      r_prod <= '0;
    end else if (w_adv) begin
      if (in_valid) begin
        r_a1 <= a;
        r_b1 <= b;
        r_e1 <= w_e_in;
      end
      if (r_v1) begin
        r_m2 <= M_W'(r_a1) * M_W'(r_b1);
        r_e2 <= r_e1;
      end
      if (r_v2) begin
        r_prod <= w_prod;
      end
    end
  end

  // A nonzero mantissa from the LOD always has its leading one in the MSB.
  a_legal_mantissa : assert property (@(posedge clk) disable iff (rst)
    (in_valid && in_ready) |-> ((a == '0 || a[FRAC_W-1]) && (b == '0 || b[FRAC_W-1])));

endmodule

// File: tb/tb_amcal3_32bit_approx_mul.sv
// Directed and scoreboarded checks of the AMCAL3 approximate multiplier pipeline.
module tb_amcal3_32bit_approx_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  a, b;
  logic [4:0]  ashift, bshift;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] prod;

  int n_checks = 0;
  int n_pass   = 0;

  amcal3_32bit_approx_mul #(.FRAC_W(3), .SHIFT_W(5), .PROD_W(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ashift(ashift), .bshift(bshift),
    .out_valid(out_valid), .out_ready(out_ready), .prod(prod)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_prod(input logic [2:0] ma, input logic [2:0] mb,
                                           input logic [4:0] sa, input logic [4:0] sb);
    logic [63:0] m;
    int e;
    m = 64'(ma) * 64'(mb);
    e = int'(sa) + int'(sb);
    if (e >= 4) return m << (e - 4);
    return m >> (4 - e);
  endfunction

  // Reference leading-one detector: leading one plus next two bits, zero-filled below bit 0.
  task automatic lod(input logic [31:0] x, output logic [2:0] m, output logic [4:0] s);
    logic [33:0] xe;
    int p;
    m = 3'b000;
    s = 5'd0;
    if (x != 32'd0) begin
      for (int i = 0; i < 32; i++) if (x[i]) s = 5'(i);
      xe = {x, 2'b00};
      p = int'(s) + 2;
      m = xe[p -: 3];
    end
  endtask

  // Push one input with out_ready high; report the product and cycles until out_valid.
  task automatic xfer(input logic [2:0] ia, input logic [2:0] ib, input logic [4:0] ias,
                      input logic [4:0] ibs, output logic [63:0] p, output int lat);
    @(negedge clk);
    a = ia; b = ib; ashift = ias; bshift = ibs;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    #1;
    p = prod;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 3'b0; b = 3'b0; ashift = 5'd0; bshift = 5'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (prod !== 64'd0) $display("FAIL reset_prod: got %h want 0", prod);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL post_reset_idle: out_valid %b in_ready %b want 0/1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_exact;
    logic [63:0] p;
    int lat;
    xfer(3'b110, 3'b100, 5'd4, 5'd2, p, lat);
    n_checks++;
    if (p !== 64'd96) $display("FAIL exact_24x4: got %0d want 96", p);
    else n_pass++;
    n_checks++;
    if (lat !== 3) $display("FAIL exact_latency: got %0d want 3", lat);
    else n_pass++;
  endtask

  task automatic test_small;
    logic [63:0] p;
    int lat;
    logic [2:0]  ta[5] = '{3'b111, 3'b110, 3'b100, 3'b111, 3'b101};
    logic [2:0]  tb[5] = '{3'b111, 3'b110, 3'b100, 3'b101, 3'b110};
    logic [4:0]  tsa[5] = '{5'd3, 5'd1, 5'd0, 5'd0, 5'd2};
    logic [4:0]  tsb[5] = '{5'd3, 5'd1, 5'd0, 5'd1, 5'd2};
    logic [63:0] texp[5] = '{64'd196, 64'd9, 64'd1, 64'd4, 64'd30};
    for (int i = 0; i < 5; i++) begin
      xfer(ta[i], tb[i], tsa[i], tsb[i], p, lat);
      n_checks++;
      if (p !== texp[i] || lat !== 3)
        $display("FAIL small_vec%0d: got %0d lat %0d want %0d lat 3", i, p, lat, texp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_zero_max;
    logic [63:0] p;
    int lat;
    xfer(3'b000, 3'b111, 5'd10, 5'd20, p, lat);
    n_checks++;
    if (p !== 64'd0) $display("FAIL zero_a: got %h want 0", p);
    else n_pass++;
    xfer(3'b101, 3'b000, 5'd31, 5'd31, p, lat);
    n_checks++;
    if (p !== 64'd0) $display("FAIL zero_b: got %h want 0", p);
    else n_pass++;
    xfer(3'b111, 3'b111, 5'd31, 5'd31, p, lat);
    n_checks++;
    if (p !== 64'hC400_0000_0000_0000) $display("FAIL max_prod: got %h want c400000000000000", p);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    logic [63:0] q[$];
    logic [63:0] exp_p, prev_p;
    logic        stalled_prev;
    int sent, got;
    sent = 0; got = 0; stalled_prev = 1'b0; prev_p = '0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c <= 6);
      in_valid = (sent < 8);
      a = 3'(4 + (sent % 4)); b = 3'(7 - (sent % 4));
      ashift = 5'(sent * 3); bshift = 5'(sent + 1);
      #1;
      n_checks++;
      if (in_ready !== (!out_valid || out_ready))
        $display("FAIL bp_in_ready c%0d: got %b want %b", c, in_ready, (!out_valid || out_ready));
      else n_pass++;
      if (stalled_prev) begin
        n_checks++;
        if (out_valid !== 1'b1 || prod !== prev_p)
          $display("FAIL bp_hold c%0d: got %h valid %b want %h valid 1", c, prod, out_valid, prev_p);
        else n_pass++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_prod(a, b, ashift, bshift));
        sent++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) $display("FAIL bp_extra_output: got %h want none", prod);
        else begin
          exp_p = q.pop_front();
          if (prod !== exp_p) $display("FAIL bp_result%0d: got %h want %h", got, prod, exp_p);
          else n_pass++;
        end
        got++;
      end
      stalled_prev = out_valid && !out_ready;
      prev_p = prod;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (got !== 8 || q.size() !== 0)
      $display("FAIL bp_count: got %0d outputs %0d pending want 8/0", got, q.size());
    else n_pass++;
  endtask

  task automatic test_reset_inflight;
    logic [63:0] p;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 3'b111; b = 3'b110; ashift = 5'(i + 5); bshift = 5'd7; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL inflight_valid: got %b want 1", out_valid);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || prod !== 64'd0)
      $display("FAIL async_reset: got valid %b prod %h want 0/0", out_valid, prod);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL async_reset_in_ready: got %b want 1", in_ready);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    xfer(3'b110, 3'b100, 5'd4, 5'd2, p, lat);
    n_checks++;
    if (lat !== 3 || p !== 64'd96)
      $display("FAIL after_reset: got %0d lat %0d want 96 lat 3", p, lat);
    else n_pass++;
  endtask

  task automatic test_random;
    localparam int N = 3000;
    logic [63:0] q[$];
    logic [63:0] exp_p;
    logic [31:0] x, y;
    logic [2:0]  ma, mb;
    logic [4:0]  sa, sb;
    logic        pending;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; pending = 1'b0;
    while (got < N && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pending && sent < N && $urandom_range(0, 4) != 0) begin
        x = ($urandom_range(0, 15) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
        y = ($urandom_range(0, 15) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
        lod(x, ma, sa);
        lod(y, mb, sb);
        a = ma; b = mb; ashift = sa; bshift = sb;
        pending = 1'b1;
      end
      in_valid = pending;
      #1;
      if (in_valid && in_ready) begin
        q.push_back(ref_prod(a, b, ashift, bshift));
        sent++;
        pending = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) $display("FAIL rand_extra_output: got %h want none", prod);
        else begin
          exp_p = q.pop_front();
          if (prod !== exp_p) $display("FAIL rand_result%0d: got %h want %h", got, prod, exp_p);
          else n_pass++;
        end
        got++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (got !== N) $display("FAIL rand_count: got %0d want %0d", got, N);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_exact();
    test_small();
    test_zero_max();
    test_backpressure();
    test_reset_inflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
